// File: rtl/sc_max7219_serializer.sv
// MAX7219 display back-end: sends the power-up init words once, then refreshes the
// intensity register and eight digit rows over the DIN/CLK/NCS serial link forever.
module sc_max7219_serializer #(
    parameter int CLKDIV_HALF = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       SC_MAX7219SER_CLOCK_50,
    input  logic       SC_MAX7219SER_RESET_InHigh,
    input  logic [7:0] SC_MAX7219SER_data_InBUS,
    input  logic [3:0] SC_MAX7219SER_intensity_InBUS,
    output logic [2:0] SC_MAX7219SER_addr_OutBUS,
    output logic       SC_MAX7219SER_DIN_Out,
    output logic       SC_MAX7219SER_CLK_Out,
    output logic       SC_MAX7219SER_NCS_Out,
    output logic       SC_MAX7219SER_frameDone_Out
);

    localparam int PHASE_W = (CLKDIV_HALF > 1) ? $clog2(CLKDIV_HALF) : 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKDIV_HALF - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0] WORD_FRAME = 4'd5;   // first word of the refresh loop
    localparam logic [3:0] WORD_LAST  = 4'd13;  // digit 8

    typedef enum logic [1:0] {
        ST_GAP,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } serStateT;

    serStateT           state, stateNext;
    logic [PHASE_W-1:0] phaseCnt, phaseNext;
    logic [GAP_W-1:0]   gapCnt, gapNext;
    logic [3:0]         bitIdx, bitNext;
    logic [3:0]         wordIdx, wordNext, wordAfter;
    logic [15:0]        shiftReg, shiftNext;
    logic               clkHigh, clkHighNext;
    logic [2:0]         addrReg, addrNext;
    logic               ncsReg, ncsNext;
    logic               clkReg, clkNext;
    logic               dinReg, dinNext;
    logic               frameDoneReg, frameDoneNext;

    // Word indices 0..4 are the one-shot init, 5 is intensity, 6..13 are digits 1..8.
    function automatic logic [15:0] wordFor(input logic [3:0] idx, input logic [7:0] data,
                                            input logic [3:0] inten);
        case (idx)
            4'd0:       wordFor = 16'h0C01;
            4'd1:       wordFor = 16'h0900;
            4'd2:       wordFor = 16'h0B07;
            4'd3, 4'd5: wordFor = {12'h0A0, inten};
            4'd4:       wordFor = 16'h0F00;
            default:    wordFor = {4'h0, idx - 4'd5, data};
        endcase
    endfunction

    assign wordAfter = (wordIdx == WORD_LAST) ? WORD_FRAME : wordIdx + 4'd1;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        stateNext     = state;
        phaseNext     = phaseCnt;
        gapNext       = gapCnt;
        bitNext       = bitIdx;
        wordNext      = wordIdx;
        shiftNext     = shiftReg;
        clkHighNext   = clkHigh;
        addrNext      = addrReg;
        frameDoneNext = 1'b0;

        case (state)
            // LATCH is the first NCS-high clock of the inter-word gap.
            ST_GAP, ST_LATCH: begin
                if (gapCnt == GAP_LAST) begin
                    stateNext = ST_LOAD;
                    gapNext   = '0;
                    shiftNext = wordFor(wordIdx, SC_MAX7219SER_data_InBUS,
                                        SC_MAX7219SER_intensity_InBUS);
                end else begin
                    stateNext = ST_GAP;
                    gapNext   = gapCnt + GAP_W'(1);
                end
            end
            ST_LOAD: begin
                stateNext   = ST_SHIFT;
                phaseNext   = '0;
                bitNext     = 4'd0;
                clkHighNext = 1'b0;
            end
            ST_SHIFT: begin
                if (phaseCnt != PHASE_LAST) begin
                    phaseNext = phaseCnt + PHASE_W'(1);
                end else begin
                    phaseNext = '0;
                    if (!clkHigh) begin
                        clkHighNext = 1'b1;
                    end else begin
                        clkHighNext = 1'b0;
                        shiftNext   = {shiftReg[14:0], 1'b0};
                        if (bitIdx == 4'd15) begin
                            stateNext     = ST_LATCH;
                            bitNext       = 4'd0;
                            gapNext       = '0;
                            frameDoneNext = (wordIdx == WORD_LAST);
                            wordNext      = wordAfter;
                            addrNext      = (wordAfter >= 4'd6) ? 3'(wordAfter - 4'd6) : 3'd0;
                        end else begin
                            bitNext = bitIdx + 4'd1;
                        end
                    end
                end
            end
            default: stateNext = ST_GAP;
        endcase

        ncsNext = !(stateNext == ST_LOAD || stateNext == ST_SHIFT);
        clkNext = (stateNext == ST_SHIFT) && clkHighNext;
        dinNext = !ncsNext && shiftNext[15];
    end

    // NOTE: pin outputs come straight from flops so the MAX7219 never sees decode glitches.
    always_ff @(posedge SC_MAX7219SER_CLOCK_50) begin
        if (SC_MAX7219SER_RESET_InHigh) begin
            state        <= ST_GAP;
            phaseCnt     <= '0;
            gapCnt       <= '0;
            bitIdx       <= 4'd0;
            wordIdx      <= 4'd0;
            shiftReg     <= 16'h0000;
            clkHigh      <= 1'b0;
            addrReg      <= 3'd0;
            ncsReg       <= 1'b1;
            clkReg       <= 1'b0;
            dinReg       <= 1'b0;
            frameDoneReg <= 1'b0;
        end else begin
            state        <= stateNext;
            phaseCnt     <= phaseNext;
            gapCnt       <= gapNext;
            bitIdx       <= bitNext;
            wordIdx      <= wordNext;
            shiftReg     <= shiftNext;
            clkHigh      <= clkHighNext;
            addrReg      <= addrNext;
            ncsReg       <= ncsNext;
            clkReg       <= clkNext;
            dinReg       <= dinNext;
            frameDoneReg <= frameDoneNext;
        end
    end

    assign SC_MAX7219SER_addr_OutBUS   = addrReg;
    assign SC_MAX7219SER_DIN_Out       = dinReg;
    assign SC_MAX7219SER_CLK_Out       = clkReg;
    assign SC_MAX7219SER_NCS_Out       = ncsReg;
    assign SC_MAX7219SER_frameDone_Out = frameDoneReg;

endmodule
